// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, DIGIT bits per
// clock, through a cascaded equal/greater chain, with optional two's-complement order.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             eqc_q, eqc_d;
    logic             gtc_q, gtc_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [DIGIT-1:0] a_dig [N];
    logic [DIGIT-1:0] b_dig [N];
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             deq, dgt;
    logic             eqc_new, gtc_new;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digit
            assign a_dig[gi] = a_q[gi*DIGIT +: DIGIT];
            assign b_dig[gi] = b_q[gi*DIGIT +: DIGIT];
        end
    endgenerate

    // Flipping the sign bit of the top digit maps two's-complement order onto unsigned order.
    always_comb begin
        dig_a = a_dig[idx_q];
        dig_b = b_dig[idx_q];
        if (sgn_q && (idx_q == TOP_IDX)) begin
            dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
            dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
        end
        deq = (dig_a == dig_b);
        dgt = (dig_a > dig_b);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        eqc_d   = eqc_q;
        gtc_d   = gtc_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        gtc_new = gtc_q | (eqc_q & dgt);
        eqc_new = eqc_q & deq;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    sgn_d   = signed_mode_i;
                    idx_d   = TOP_IDX;
                    eqc_d   = 1'b1;
                    gtc_d   = 1'b0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                gtc_d = gtc_new;
                eqc_d = eqc_new;
                // Stop at the first differing digit; lower digits cannot change the outcome.
                if (!eqc_new || (idx_q == '0)) begin
                    state_d = S_DONE;
                    eq_d    = eqc_new;
                    gt_d    = gtc_new;
                    lt_d    = ~eqc_new & ~gtc_new;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            eqc_q   <= 1'b0;
            gtc_q   <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            eqc_q   <= eqc_d;
            gtc_q   <= gtc_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign eq_o   = eq_q;
    assign gt_o   = gt_q;
    assign lt_o   = lt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: an 8-bit/2-bit-digit instance and a 32-bit/4-bit-digit
// instance, each tracked every cycle by an arithmetic reference model.
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, sgn0 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic        start1 = 1'b0, sgn1 = 1'b0;
    logic [31:0] a1 = '0, b1 = '0;
    logic        busy0, done0, eq0, gt0, lt0;
    logic        busy1, done1, eq1, gt1, lt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clock_i(clk), .reset_i(rst_n), .start_i(start0), .signed_mode_i(sgn0),
        .a_i(a0), .b_i(b0), .busy_o(busy0), .done_o(done0),
        .eq_o(eq0), .gt_o(gt0), .lt_o(lt0)
    );

    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) dut32 (
        .clock_i(clk), .reset_i(rst_n), .start_i(start1), .signed_mode_i(sgn1),
        .a_i(a1), .b_i(b1), .busy_o(busy1), .done_o(done1),
        .eq_o(eq1), .gt_o(gt1), .lt_o(lt1)
    );

    // ---------------- reference model ----------------
    int       m_w [2] = '{8, 32};
    int       m_d [2] = '{2, 4};
    bit       m_busy [2];
    bit       m_done [2];
    logic [2:0] m_res  [2];   // {eq, gt, lt}
    logic [2:0] m_pend [2];
    int       m_cnt [2];
    bit       model_ok = 1'b0;

    // k = 1 + number of leading equal digits (capped at N); result from plain integer compare.
    function automatic void compute(input int w, input int d, input logic [31:0] a,
                                    input logic [31:0] b, input logic s,
                                    output int k, output logic [2:0] res);
        longint va, vb;
        longint mask;
        int n, lead;
        bit still_eq;
        n    = w / d;
        mask = (longint'(1) << w) - 1;
        va   = longint'(a) & mask;
        vb   = longint'(b) & mask;
        if (s && a[w-1]) va = va - (longint'(1) << w);
        if (s && b[w-1]) vb = vb - (longint'(1) << w);
        lead = 0;
        still_eq = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            if (still_eq && (((a >> (i*d)) & ((32'd1 << d) - 1)) == ((b >> (i*d)) & ((32'd1 << d) - 1))))
                lead++;
            else
                still_eq = 1'b0;
        end
        k = (lead + 1 > n) ? n : lead + 1;
        res = (va == vb) ? 3'b100 : (va > vb) ? 3'b010 : 3'b001;
    endfunction

    task automatic model_step(input int u, input logic st, input logic [31:0] a,
                              input logic [31:0] b, input logic s);
        int k;
        logic [2:0] r;
        if (!rst_n) begin
            m_busy[u] = 1'b0; m_done[u] = 1'b0; m_res[u] = 3'b000; m_cnt[u] = 0;
        end else if (m_busy[u]) begin
            m_cnt[u]--;
            if (m_cnt[u] == 0) begin
                m_busy[u] = 1'b0;
                m_done[u] = 1'b1;
                m_res[u]  = m_pend[u];
            end
        end else begin
            m_done[u] = 1'b0;
            if (st) begin
                compute(m_w[u], m_d[u], a, b, s, k, r);
                m_pend[u] = r;
                m_cnt[u]  = k;
                m_busy[u] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, start0, {24'd0, a0}, {24'd0, b0}, sgn0);
        model_step(1, start1, a1, b1, sgn1);
        model_ok = 1'b1;
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            logic [4:0] act [2];
            logic [4:0] exp_v;
            act[0] = {busy0, done0, eq0, gt0, lt0};
            act[1] = {busy1, done1, eq1, gt1, lt1};
            for (int u = 0; u < 2; u++) begin
                exp_v = {m_busy[u], m_done[u], m_res[u]};
                n_checks++;
                if (act[u] !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cycle inst%0d t=%0t: {busy,done,eq,gt,lt} got %b expected %b",
                             u, $time, act[u], exp_v);
                end
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Entered at the negedge of the first cycle after the start edge (lat = 1).
    task automatic wait_done(input int u, input int lat0, input string name,
                             input int exp_lat, input logic [2:0] exp_res);
        int lat;
        logic d;
        lat = lat0;
        d = (u == 0) ? done0 : done1;
        while (!d && lat < 50) begin
            @(negedge clk);
            lat++;
            d = (u == 0) ? done0 : done1;
        end
        check({name, "_latency"}, lat, exp_lat);
        if (u == 0) check({name, "_result"}, {eq0, gt0, lt0}, exp_res);
        else        check({name, "_result"}, {eq1, gt1, lt1}, exp_res);
        $display("txn %s: latency %0d result %b", name, lat,
                 (u == 0) ? {eq0, gt0, lt0} : {eq1, gt1, lt1});
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input int exp_lat, input logic [2:0] exp_res);
        @(negedge clk);
        a0 = a; b0 = b; sgn0 = s; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 1, name, exp_lat, exp_res);
    endtask

    initial begin
        // Reset held with start asserted: everything stays cleared.
        rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold8", {busy0, done0, eq0, gt0, lt0}, 5'b0);
            check("reset_hold32", {busy1, done1, eq1, gt1, lt1}, 5'b0);
        end
        start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
        $display("txn reset: outputs cleared");

        run8("uns_A5_A5", 8'hA5, 8'hA5, 1'b0, 5, 3'b100);
        run8("uns_80_7F", 8'h80, 8'h7F, 1'b0, 2, 3'b010);
        run8("sgn_80_7F", 8'h80, 8'h7F, 1'b1, 2, 3'b001);
        run8("sgn_FE_FD", 8'hFE, 8'hFD, 1'b1, 5, 3'b010);
        run8("sgn_7F_80", 8'h7F, 8'h80, 1'b1, 2, 3'b010);
        run8("uns_12_13", 8'h12, 8'h13, 1'b0, 5, 3'b001);

        // start while busy with operands changed: ignored, original A5 vs A4 wins.
        @(negedge clk);
        a0 = 8'hA5; b0 = 8'hA4; sgn0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        a0 = 8'h00; b0 = 8'hFF; sgn0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 2, "busy_ignore", 5, 3'b010);

        // Back-to-back: start asserted in the done cycle.
        run8("b2b_first", 8'h80, 8'h7F, 1'b0, 2, 3'b010);
        a0 = 8'h12; b0 = 8'h34; sgn0 = 1'b0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("b2b_no_gap_busy", {31'd0, busy0}, 32'd1);
        check("b2b_result_held", {eq0, gt0, lt0}, 3'b010);
        wait_done(0, 1, "b2b_second", 3, 3'b001);

        // Reset mid-RUN aborts with no done pulse.
        @(negedge clk);
        a0 = 8'hA5; b0 = 8'hA5; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_cleared", {busy0, done0, eq0, gt0, lt0}, 5'b0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done0}, 32'd0);
        end
        $display("txn abort: no done after mid-run reset");

        // Wide instance: 8 digits of 4 bits, equal operands run the full length.
        @(negedge clk);
        a1 = 32'hDEADBEEF; b1 = 32'hDEADBEEF; sgn1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 1, "w32_DEADBEEF", 9, 3'b100);

        @(negedge clk);
        a1 = 32'h80000000; b1 = 32'h00000001; sgn1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1, 1, "w32_signed_neg", 2, 3'b001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
